// File: rtl/sort_frame_loader.sv
// Frame loader for the top-K sorter: buffers one frame from a valid/ready stream,
// saturates samples to the sorter width and runs the start/wait/clear handshake.
module sort_frame_loader #(
    parameter int DATA_NUM    = 40,
    parameter int DATA_LENGTH = 14,
    parameter int IN_LENGTH   = 16,
    parameter int NUM_WIDTH   = 6,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [IN_LENGTH-1:0]   in_data_i,
    input  logic                   in_last_i,
    output logic [DATA_LENGTH-1:0] data_o [DATA_NUM],
    output logic                   sort_start_o,
    input  logic                   sort_finish_i,
    output logic [NUM_WIDTH-1:0]   frame_len_o,
    output logic                   busy_o,
    output logic                   err_len_o,
    output logic                   err_timeout_o
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [IN_LENGTH-1:0]   SAT_LIM = IN_LENGTH'((2 ** DATA_LENGTH) - 1);
    localparam logic [DATA_LENGTH-1:0] SAT_VAL = DATA_LENGTH'((2 ** DATA_LENGTH) - 2);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_LENGTH-1:0] data_q [DATA_NUM];
    logic [DATA_LENGTH-1:0] data_d [DATA_NUM];
    logic [NUM_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [NUM_WIDTH-1:0]   frame_len_q, frame_len_d;
    logic [WC_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic                   err_len_q, err_len_d;
    logic                   err_timeout_q, err_timeout_d;
    logic                   accept_s;

    // Zero stays "no data"; large values clip below the all-ones sentinel.
    function automatic logic [DATA_LENGTH-1:0] sat(input logic [IN_LENGTH-1:0] x);
        logic [DATA_LENGTH-1:0] r;
        if (x == '0) begin
            r = '0;
        end else if (x >= SAT_LIM) begin
            r = SAT_VAL;
        end else begin
            r = x[DATA_LENGTH-1:0];
        end
        return r;
    endfunction

    assign accept_s = in_valid_i && (state_q == S_FILL);

    // Next-state logic for the frame FSM, buffer, counters and sticky errors.
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        wr_ptr_d      = wr_ptr_q;
        frame_len_d   = frame_len_q;
        wait_cnt_d    = wait_cnt_q;
        err_len_d     = err_len_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            S_FILL: begin
                if (accept_s) begin
                    data_d[wr_ptr_q] = sat(in_data_i);
                    wr_ptr_d         = wr_ptr_q + NUM_WIDTH'(1);
                    frame_len_d      = wr_ptr_q + NUM_WIDTH'(1);
                    if (wr_ptr_q == NUM_WIDTH'(DATA_NUM - 1)) begin
                        state_d   = S_START;
                        err_len_d = err_len_q | ~in_last_i;
                    end else if (in_last_i) begin
                        state_d = S_START;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_START: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
                // The first two WAIT cycles mask a stale finish from the sorter's free-run.
                if (sort_finish_i && (wait_cnt_q >= WC_W'(2))) begin
                    state_d = S_CLEAR;
                end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_CLEAR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_CLEAR: begin
                for (int i = 0; i < DATA_NUM; i++) begin
                    data_d[i] = '0;
                end
                wr_ptr_d = '0;
                state_d  = S_FILL;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State and buffer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_FILL;
            for (int i = 0; i < DATA_NUM; i++) begin
                data_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            frame_len_q   <= '0;
            wait_cnt_q    <= '0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            wr_ptr_q      <= wr_ptr_d;
            frame_len_q   <= frame_len_d;
            wait_cnt_q    <= wait_cnt_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign data_o        = data_q;
    assign in_ready_o    = (state_q == S_FILL);
    assign sort_start_o  = (state_q == S_START);
    assign busy_o        = (state_q != S_FILL);
    assign frame_len_o   = frame_len_q;
    assign err_len_o     = err_len_q;
    assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Directed bench for sort_frame_loader: frame loading, saturation, length/timeout
// errors, reset mid-sort and the finish/timeout tie.
module tb_sort_frame_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic [13:0] data [40];
    logic        sort_start;
    logic        sort_finish;
    logic [5:0]  frame_len;
    logic        busy;
    logic        err_len;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;
    logic [13:0] exp_mem [40];

    sort_frame_loader dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .in_last_i     (in_last),
        .data_o        (data),
        .sort_start_o  (sort_start),
        .sort_finish_i (sort_finish),
        .frame_len_o   (frame_len),
        .busy_o        (busy),
        .err_len_o     (err_len),
        .err_timeout_o (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_mem(input string tag);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("%s[%0d]", tag, i), 32'(data[i]), 32'(exp_mem[i]));
        end
    endtask

    task automatic clr_exp();
        for (int i = 0; i < 40; i++) exp_mem[i] = 14'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [15:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        chk("send_ready_timeout", 32'(n < 200), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Entered one cycle after the START edge; finish in WAIT cycle wait_cnt=2.
    task automatic finish_sort(input logic [5:0] exp_len);
        chk("start_pulse", 32'(sort_start), 32'd1);
        chk("start_not_ready", 32'(in_ready), 32'd0);
        step();
        chk("start_one_cycle", 32'(sort_start), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        step();
        step();
        sort_finish = 1'b1;
        step();
        sort_finish = 1'b0;
        chk("clear_not_ready", 32'(in_ready), 32'd0);
        step();
        chk("fill_ready", 32'(in_ready), 32'd1);
        chk("fill_not_busy", 32'(busy), 32'd0);
        chk("frame_len_hold", 32'(frame_len), 32'(exp_len));
        clr_exp();
        chk_mem("cleared");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; sort_finish = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_start", 32'(sort_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_len", 32'(frame_len), 32'd0);
        chk("rst_errl", 32'(err_len), 32'd0);
        chk("rst_errt", 32'(err_timeout), 32'd0);
        clr_exp();
        chk_mem("rst_data");

        // Full 40-entry frame of 1..40
        for (int i = 1; i <= 40; i++) send(16'(i), (i == 40));
        for (int i = 0; i < 40; i++) exp_mem[i] = 14'(i + 1);
        chk_mem("full");
        chk("full_len", 32'(frame_len), 32'd40);
        chk("full_errl", 32'(err_len), 32'd0);
        finish_sort(6'd40);

        // Short frame of 5
        send(16'd100, 1'b0); send(16'd200, 1'b0); send(16'd300, 1'b0);
        send(16'd400, 1'b0); send(16'd500, 1'b1);
        clr_exp();
        exp_mem[0] = 14'd100; exp_mem[1] = 14'd200; exp_mem[2] = 14'd300;
        exp_mem[3] = 14'd400; exp_mem[4] = 14'd500;
        chk_mem("short");
        chk("short_len", 32'(frame_len), 32'd5);
        finish_sort(6'd5);

        // Saturation
        send(16'h0000, 1'b0); send(16'h3FFE, 1'b0); send(16'h3FFF, 1'b0);
        send(16'hFFFF, 1'b0); send(16'h0123, 1'b1);
        clr_exp();
        exp_mem[1] = 14'h3FFE; exp_mem[2] = 14'h3FFE; exp_mem[3] = 14'h3FFE;
        exp_mem[4] = 14'h0123;
        chk_mem("sat");
        finish_sort(6'd5);

        // 41 beats without in_last
        for (int i = 1; i <= 40; i++) send(16'(i), 1'b0);
        chk("ovf_errl", 32'(err_len), 32'd1);
        chk("ovf_len", 32'(frame_len), 32'd40);
        in_valid = 1'b1; in_data = 16'd41; in_last = 1'b0;
        finish_sort(6'd40);
        step();
        in_valid = 1'b0;
        chk("ovf_carry_data0", 32'(data[0]), 32'd41);
        chk("ovf_carry_len", 32'(frame_len), 32'd1);
        send(16'd7, 1'b1);
        chk("ovf_data1", 32'(data[1]), 32'd7);
        chk("ovf_len2", 32'(frame_len), 32'd2);
        finish_sort(6'd2);
        chk("errl_sticky", 32'(err_len), 32'd1);

        // Timeout, with an early finish that must be ignored
        send(16'd9, 1'b0); send(16'd8, 1'b0); send(16'd6, 1'b1);
        chk("to_start", 32'(sort_start), 32'd1);
        step();
        sort_finish = 1'b1;
        step();
        sort_finish = 1'b0;
        chk("early_finish_ignored", 32'(busy), 32'd1);
        chk("early_finish_data", 32'(data[2]), 32'd6);
        for (int i = 0; i < 62; i++) step();
        chk("to_last_wait_busy", 32'(in_ready), 32'd0);
        chk("to_not_yet", 32'(err_timeout), 32'd0);
        step();
        chk("to_set", 32'(err_timeout), 32'd1);
        chk("to_clear_not_ready", 32'(in_ready), 32'd0);
        step();
        chk("to_ready", 32'(in_ready), 32'd1);
        clr_exp();
        chk_mem("to_cleared");

        // Reset during WAIT
        send(16'd55, 1'b0); send(16'd66, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_ready", 32'(in_ready), 32'd1);
        chk("rstw_start", 32'(sort_start), 32'd0);
        chk("rstw_errl", 32'(err_len), 32'd0);
        chk("rstw_errt", 32'(err_timeout), 32'd0);
        chk("rstw_len", 32'(frame_len), 32'd0);
        chk_mem("rstw_data");
        sort_finish = 1'b1;
        step();
        sort_finish = 1'b0;
        step();
        chk("late_finish_busy", 32'(busy), 32'd0);
        chk("late_finish_ready", 32'(in_ready), 32'd1);
        chk("late_finish_start", 32'(sort_start), 32'd0);

        // Finish coinciding with the timeout cycle wins
        send(16'd3, 1'b1);
        chk("tie_start", 32'(sort_start), 32'd1);
        for (int i = 0; i < 64; i++) step();
        chk("tie_busy", 32'(busy), 32'd1);
        sort_finish = 1'b1;
        step();
        sort_finish = 1'b0;
        chk("tie_errt", 32'(err_timeout), 32'd0);
        step();
        chk("tie_ready", 32'(in_ready), 32'd1);
        chk("tie_errt_after", 32'(err_timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
